// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational instruction
// memory, inserts wait states, buffers words in a 2-entry queue and hands them to
// decode over a valid/ready handshake. Handles branch redirect, end of memory and
// illegal-target faults.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int unsigned MEM_BYTES   = 400,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        done,
    output logic        fault
);

    localparam logic [31:0] EndAddr  = 32'(MEM_BYTES);
    localparam logic [31:0] LastAddr = 32'(MEM_BYTES - 4);
    localparam logic [3:0]  WaitMax  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StFetch, StEnd, StFault} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [3:0]  wait_q;
    logic        fault_q;

    // Queue entries are {instr, pc}; entry 0 is always the head.
    logic [63:0] e0_q, e0_d;
    logic [63:0] e1_q, e1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  cnt_after_pop;

    logic pop;
    logic branch_act;
    logic target_ok;
    logic capture;

    assign pop        = (cnt_q != 2'd0) && instr_ready;
    assign branch_act = branch_taken && (state_q != StFault);
    assign target_ok  = (branch_target[1:0] == 2'b00) && (branch_target <= LastAddr);
    // Branch wins over capture: a word fetched in the redirect cycle is dropped.
    assign capture    = (state_q == StFetch) && (wait_q == WaitMax) &&
                        ((cnt_q != 2'd2) || pop) && !branch_act;

    // Queue next-state: pop first, then flush or push into the first free slot.
    // Entry 0 is only overwritten by a shift or a push, so the head holds its
    // last value while the queue is empty.
    always_comb begin
        e0_d          = e0_q;
        e1_d          = e1_q;
        cnt_after_pop = cnt_q - {1'b0, pop};
        cnt_d         = cnt_after_pop;
        if (pop && (cnt_q == 2'd2)) begin
            e0_d = e1_q;
        end
        if (branch_act) begin
            cnt_d = 2'd0;
        end else if (capture) begin
            if (cnt_after_pop == 2'd0) begin
                e0_d = {mem_data, pc_q};
            end else begin
                e1_d = {mem_data, pc_q};
            end
            cnt_d = cnt_after_pop + 2'd1;
        end
    end

    // Queue storage and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= 64'd0;
            e1_q  <= 64'd0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    // Fetch FSM: state, PC, wait-state counter and sticky fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            wait_q  <= 4'd0;
            fault_q <= 1'b0;
        end else if (branch_act) begin
            if (target_ok) begin
                pc_q    <= branch_target;
                wait_q  <= 4'd0;
                state_q <= StFetch;
            end else begin
                state_q <= StFault;
                fault_q <= 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StFetch;
                        wait_q  <= 4'd0;
                    end
                end
                StFetch: begin
                    if (capture) begin
                        pc_q   <= pc_q + 32'd4;
                        wait_q <= 4'd0;
                        if (pc_q + 32'd4 == EndAddr) begin
                            state_q <= StEnd;
                        end
                    end else if (wait_q != WaitMax) begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                StEnd, StFault: begin
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_addr    = pc_q;
    assign instr       = e0_q[63:32];
    assign instr_pc    = e0_q[31:0];
    assign instr_valid = (cnt_q != 2'd0);
    assign done        = (state_q == StEnd) && (cnt_q == 2'd0);
    assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: one instance with no wait states and one
// with three, each fed by a combinational memory model.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        done;
    logic        fault;

    logic        start_w;
    logic [31:0] mem_addr_w;
    logic [31:0] mem_data_w;
    logic [31:0] instr_w;
    logic [31:0] instr_pc_w;
    logic        instr_valid_w;
    logic        instr_ready_w;
    logic        done_w;
    logic        fault_w;

    int n_vec;
    int n_err;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {16'hC0DE ^ a[15:0], a[15:0]};
    endfunction

    assign mem_data   = memw(mem_addr);
    assign mem_data_w = memw(mem_addr_w);

    instr_fetch_ctrl #(
        .RESET_PC    (32'd0),
        .MEM_BYTES   (400),
        .WAIT_STATES (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .done          (done),
        .fault         (fault)
    );

    instr_fetch_ctrl #(
        .RESET_PC    (32'd0),
        .MEM_BYTES   (400),
        .WAIT_STATES (3)
    ) dut_ws (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start_w),
        .mem_addr      (mem_addr_w),
        .mem_data      (mem_data_w),
        .instr         (instr_w),
        .instr_pc      (instr_pc_w),
        .instr_valid   (instr_valid_w),
        .instr_ready   (instr_ready_w),
        .branch_taken  (1'b0),
        .branch_target (32'd0),
        .done          (done_w),
        .fault         (fault_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted and released around a falling edge, away from the active edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        start        = 1'b0;
        start_w      = 1'b0;
        branch_taken = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic fault_case(input logic [31:0] target, input string tag);
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check({tag, "_pre_addr"}, mem_addr, 32'd4);
        branch_taken  = 1'b1;
        branch_target = target;
        tick();
        branch_taken = 1'b0;
        check({tag, "_fault"}, fault, 1'b1);
        check({tag, "_valid"}, instr_valid, 1'b0);
        check({tag, "_addr"}, mem_addr, 32'd4);
        // Neither a legal branch nor START may leave FAULT.
        branch_taken  = 1'b1;
        branch_target = 32'd0;
        start = 1'b1;
        tick();
        tick();
        branch_taken = 1'b0;
        start = 1'b0;
        tick();
        check({tag, "_sticky"}, fault, 1'b1);
        check({tag, "_frozen"}, mem_addr, 32'd4);
        check({tag, "_valid2"}, instr_valid, 1'b0);
        do_reset();
        #1;
        check({tag, "_cleared"}, fault, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        start_w = 1'b0;
        instr_ready = 1'b1;
        instr_ready_w = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        #2;
        check("rst_addr", mem_addr, 32'd0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_done", done, 1'b0);
        check("rst_fault", fault, 1'b0);

        // 1. Start-up latency and one word per cycle.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_valid_k", instr_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_valid", instr_valid, 1'b1);
            check("t1_pc", instr_pc, 32'(4 * i));
            check("t1_instr", instr, memw(32'(4 * i)));
        end

        // 2. Back-pressure fills the queue, then in-order drain.
        do_reset();
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t2_head", instr_pc, 32'd0);
        check("t2_addr", mem_addr, 32'd8);
        instr_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            check("t2_drain", instr_pc, 32'(4 * i));
        end

        // 3. Branch with a full queue: head consumed, tail flushed.
        do_reset();
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t3_full_addr", mem_addr, 32'd8);
        instr_ready   = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        check("t3_flushed", instr_valid, 1'b0);
        check("t3_addr", mem_addr, 32'h40);
        tick();
        check("t3_valid", instr_valid, 1'b1);
        check("t3_pc", instr_pc, 32'h40);
        check("t3_instr", instr, memw(32'h40));

        // 4. Misaligned and out-of-range targets.
        fault_case(32'h42, "t4_misal");
        fault_case(32'd400, "t4_range");

        // 5. Run to the end of memory, then restart via branch.
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("t5_pc", instr_pc, 32'(4 * i));
            if (i < 99) check("t5_notdone", done, 1'b0);
        end
        check("t5_end_addr", mem_addr, 32'd400);
        tick();
        check("t5_done", done, 1'b1);
        check("t5_empty", instr_valid, 1'b0);
        tick();
        check("t5_end_hold", mem_addr, 32'd400);
        branch_taken  = 1'b1;
        branch_target = 32'd0;
        tick();
        branch_taken = 1'b0;
        check("t5_restart_done", done, 1'b0);
        tick();
        check("t5_restart_pc", instr_pc, 32'd0);
        check("t5_restart_valid", instr_valid, 1'b1);

        // 6. Three wait states, then asynchronous reset during a wait.
        do_reset();
        instr_ready_w = 1'b0;
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_wait", instr_valid_w, 1'b0);
        end
        tick();
        check("t6_cap0", instr_valid_w, 1'b1);
        check("t6_pc0", instr_pc_w, 32'd0);
        check("t6_instr0", instr_w, memw(32'd0));
        instr_ready_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_gap", instr_valid_w, 1'b0);
        end
        check("t6_addr", mem_addr_w, 32'd4);
        tick();
        check("t6_cap1", instr_valid_w, 1'b1);
        check("t6_pc1", instr_pc_w, 32'd4);
        instr_ready_w = 1'b0;
        tick();
        check("t6_hold", instr_valid_w, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", instr_valid_w, 1'b0);
        check("t6_async_pc", instr_pc_w, 32'd0);
        check("t6_async_instr", instr_w, 32'd0);
        check("t6_async_addr", mem_addr_w, 32'd0);
        #3;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
